// File: rtl/fifo_rd_stream.sv
// Read-side controller for the 32-bit BRAM FIFO: reset sequencing, occupancy tracking,
// latency-absorbing skid buffer and valid/ready output. Optional stats: FIFO_RD_STREAM_STATS_EN.
module fifo_rd_stream #(
  parameter int DEPTH          = 512,
  parameter int READ_LATENCY   = 2,
  parameter int SKID_DEPTH     = 4,
  parameter int RST_CYCLES     = 5,
  parameter int HOLDOFF_CYCLES = 4,
  localparam int OCC_W         = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             fifo_rst,
  output logic             fifo_ready,
  input  logic             wr_commit,
  output logic             fifo_ren,
  input  logic [31:0]      fifo_dout,
  output logic [31:0]      m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OCC_W-1:0] occupancy,
  output logic             overflow
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [31:0]      words_out,
  output logic [OCC_W-1:0] occ_max
`endif
);

  localparam int CNT_MAX = (RST_CYCLES > HOLDOFF_CYCLES) ? RST_CYCLES : HOLDOFF_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IF_W    = $clog2(READ_LATENCY + 1);
  localparam int SC_W    = $clog2(SKID_DEPTH + 1);
  localparam int PTR_W   = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;

  typedef enum logic [1:0] {S_RESET, S_RSTHOLD, S_HOLDOFF, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RESET: begin
        state_d = S_RSTHOLD;
        cnt_d   = '0;
      end
      S_RSTHOLD: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          state_d = S_HOLDOFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLDOFF: begin
        if (cnt_q == CNT_W'(HOLDOFF_CYCLES - 1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign run        = (state_q == S_RUN);
  assign fifo_ready = run;
  assign fifo_rst   = (state_q == S_RESET) || (state_q == S_RSTHOLD);

  // Read-latency pipeline: one valid bit per outstanding read.
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [IF_W-1:0]         inflight;
  logic                    push;

  generate
    for (genvar gi = 0; gi < READ_LATENCY; gi++) begin : g_vld
      if (gi == 0) begin : g_head
        assign vld_d[gi] = fifo_ren;
      end else begin : g_tail
        assign vld_d[gi] = vld_q[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) vld_q <= '0;
    else      vld_q <= vld_d;
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + IF_W'(vld_q[i]);
  end

  assign push = vld_q[READ_LATENCY-1];

  logic [31:0]      skid_mem [SKID_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [SC_W-1:0]  skid_cnt_q;
  logic             pop;

  assign m_valid = (skid_cnt_q != '0);
  assign m_data  = skid_mem[rd_ptr_q];
  assign pop     = m_valid & m_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < SKID_DEPTH; i++) skid_mem[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      skid_cnt_q <= '0;
    end else begin
      if (push) begin
        skid_mem[wr_ptr_q] <= fifo_dout;
        wr_ptr_q <= (wr_ptr_q == PTR_W'(SKID_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= (rd_ptr_q == PTR_W'(SKID_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   skid_cnt_q <= skid_cnt_q + 1'b1;
        2'b01:   skid_cnt_q <= skid_cnt_q - 1'b1;
        default: skid_cnt_q <= skid_cnt_q;
      endcase
    end
  end

  // A read is only issued when its data is guaranteed a skid slot on arrival.
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             ovf_q, ovf_d;
  logic [31:0]      pending;
  logic             wr;

  assign pending  = 32'(inflight) + 32'(skid_cnt_q) - 32'(pop);
  assign fifo_ren = run && (occ_q != '0) && (pending < 32'(SKID_DEPTH));
  assign wr       = wr_commit & run;

  always_comb begin
    occ_d = occ_q;
    ovf_d = ovf_q;
    if (wr && occ_q == OCC_W'(DEPTH)) ovf_d = 1'b1;
    case ({wr, fifo_ren})
      2'b10:   if (occ_q != OCC_W'(DEPTH)) occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      occ_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
      ovf_q <= ovf_d;
    end
  end

  assign occupancy = occ_q;
  assign overflow  = ovf_q;

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0]      words_q;
  logic [OCC_W-1:0] occ_max_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      words_q   <= '0;
      occ_max_q <= '0;
    end else begin
      words_q <= words_q + 32'(pop);
      if (occ_d > occ_max_q) occ_max_q <= occ_d;
    end
  end

  assign words_out = words_q;
  assign occ_max   = occ_max_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: BRAM FIFO emulator plus a word-level model of
// occupancy, read issue, arrival times and output order.
module tb_fifo_rd_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_rst, fifo_ready, wr_commit, fifo_ren, m_valid, m_ready, overflow;
  logic [31:0] fifo_dout, m_data;
  logic [9:0]  occupancy;
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0] words_out;
  logic [9:0]  occ_max;
`endif

  fifo_rd_stream dut (
    .clk(clk), .rst(rst), .fifo_rst(fifo_rst), .fifo_ready(fifo_ready),
    .wr_commit(wr_commit), .fifo_ren(fifo_ren), .fifo_dout(fifo_dout),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .occupancy(occupancy), .overflow(overflow)
`ifdef FIFO_RD_STREAM_STATS_EN
    , .words_out(words_out), .occ_max(occ_max)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rel_cnt = 0;
  bit          started = 0;
  int          occ_m = 0;
  bit          ovf_m = 0;
  int          delivered = 0;
  bit          last_ren = 0;
  logic [31:0] wdata = '0;
  logic [31:0] st1 = '0;
  int          arr_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] mem_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: check at the falling edge, advance model and FIFO emulator after the rising edge.
  task automatic cycle();
    bit run_e, mvalid_e, pop_e, ren_e, ren_obs, wr_e, accept;
    @(negedge clk);
    run_e    = started && rel_cnt >= 10;
    mvalid_e = started && arr_q.size() > 0 && arr_q[0] <= cyc;
    pop_e    = mvalid_e && m_ready;
    ren_e    = run_e && occ_m != 0 && (arr_q.size() - (pop_e ? 1 : 0)) < 4;
    ren_obs  = fifo_ren;
    if (started) begin
      chk("fifo_rst", fifo_rst, rel_cnt <= 5);
      chk("fifo_ready", fifo_ready, run_e);
      chk("fifo_ren", fifo_ren, ren_e);
      chk("m_valid", m_valid, mvalid_e);
      if (mvalid_e && exp_q.size() > 0) chk("m_data", m_data, exp_q[0]);
      if (rel_cnt == 0) chk("m_data_rst", m_data, 32'h0);
      chk("occupancy", occupancy, occ_m);
      chk("overflow", overflow, ovf_m);
    end
    last_ren = ren_obs;
    if (pop_e) delivered++;
    @(posedge clk);
    #1;
    if (!rst) begin
      started = 1;
      rel_cnt = 0;
      occ_m = 0;
      ovf_m = 0;
      arr_q.delete();
      exp_q.delete();
      mem_q.delete();
      st1 = '0;
      fifo_dout = '0;
    end else if (started) begin
      if (rel_cnt <= 5) begin
        mem_q.delete();
        st1 = '0;
        fifo_dout = '0;
      end else begin
        fifo_dout = st1;
        if (ren_obs) st1 = (mem_q.size() > 0) ? mem_q.pop_front() : 32'hDEADBEEF;
      end
      if (pop_e) begin
        void'(arr_q.pop_front());
        void'(exp_q.pop_front());
      end
      if (ren_e) arr_q.push_back(cyc + 3);
      wr_e   = run_e && wr_commit;
      accept = wr_e && !(occ_m == 512 && !ren_e);
      if (wr_e && occ_m == 512) ovf_m = 1;
      if (wr_e && !ren_e && occ_m != 512) occ_m++;
      else if (!wr_e && ren_e) occ_m--;
      if (accept) begin
        exp_q.push_back(wdata);
        mem_q.push_back(wdata);
      end
      if (rel_cnt < 100) rel_cnt++;
    end
    cyc++;
  endtask

  task automatic reset_seq();
    rst = 1'b0;
    wr_commit = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      wr_commit = (i == 7);
      wdata = 32'hBAD0_0000 + i;
      cycle();
    end
    wr_commit = 1'b0;
  endtask

  initial begin
    int ren_cnt;
    int d0;
    rst = 1'b0;
    wr_commit = 1'b0;
    m_ready = 1'b0;
    fifo_dout = '0;

    $display("step: reset sequence with a write attempted during holdoff");
    reset_seq();
    chk("reset_occ_after_holdoff_write", occupancy, 0);

    $display("step: stream 0x1..0x10 with m_ready high");
    m_ready = 1'b1;
    d0 = delivered;
    for (int i = 0; i < 16; i++) begin
      wr_commit = 1'b1;
      wdata = 32'(i + 1);
      cycle();
    end
    wr_commit = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    chk("stream_count", delivered - d0, 16);
    chk("stream_occ_end", occupancy, 0);

    $display("step: backpressure, 8 words with m_ready low for 20 cycles");
    m_ready = 1'b0;
    ren_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      wr_commit = (i < 8);
      wdata = 32'(i + 1);
      cycle();
      ren_cnt += int'(last_ren);
    end
    wr_commit = 1'b0;
    chk("bp_ren_pulses", ren_cnt, 4);
    chk("bp_occ", occupancy, 4);
    chk("bp_head", m_data, 32'h1);
    d0 = delivered;
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) cycle();
    chk("bp_delivered", delivered - d0, 8);

    $display("step: simultaneous write and read at occupancy 7");
    m_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      wr_commit = (i < 11);
      wdata = $urandom;
      cycle();
    end
    chk("simul_occ_before", occupancy, 7);
    m_ready = 1'b1;
    wr_commit = 1'b1;
    wdata = $urandom;
    cycle();
    wr_commit = 1'b0;
    chk("simul_ren", last_ren, 1);
    chk("simul_occ_after", occupancy, 7);
    for (int i = 0; i < 20; i++) cycle();
    chk("simul_drained", occupancy, 0);

    $display("step: fill to capacity with m_ready low, then one extra write");
    m_ready = 1'b0;
    for (int i = 0; i < 600 && occ_m < 512; i++) begin
      wr_commit = 1'b1;
      wdata = $urandom;
      cycle();
    end
    wr_commit = 1'b0;
    cycle();
    chk("full_occ", occupancy, 512);
    chk("full_no_ovf", overflow, 0);
    wr_commit = 1'b1;
    wdata = $urandom;
    cycle();
    wr_commit = 1'b0;
    cycle();
    chk("ovf_set", overflow, 1);
    chk("ovf_occ_sat", occupancy, 512);
    m_ready = 1'b1;
    for (int i = 0; i < 30; i++) cycle();
    chk("ovf_sticky", overflow, 1);

    $display("step: reset asserted while reads are in flight");
    reset_seq();
    chk("ovf_cleared", overflow, 0);
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_commit = 1'b1;
      wdata = 32'hC000_0000 + i;
      cycle();
    end
    wr_commit = 1'b0;
    rst = 1'b0;
    cycle();
    chk("midrst_valid", m_valid, 0);
    chk("midrst_occ", occupancy, 0);
    d0 = delivered;
    rst = 1'b1;
    for (int i = 0; i < 30; i++) cycle();
    chk("midrst_no_stale", delivered - d0, 0);

    $display("step: randomized writes and backpressure for 2000 cycles");
    for (int i = 0; i < 2000; i++) begin
      wr_commit = (rel_cnt >= 10) && occ_m < 480 && ($urandom_range(0, 3) != 0);
      wdata = $urandom;
      m_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end
    wr_commit = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 600 && (occ_m != 0 || arr_q.size() != 0); i++) cycle();
    for (int i = 0; i < 5; i++) cycle();
    chk("rand_occ_end", occupancy, 0);
    chk("rand_valid_end", m_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
